// File: rtl/sqrt_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : sqrt_rr_scheduler
// Purpose : Round-robin shared non-restoring square-root engine, one root bit
//           per cycle, with valid/ready request and response handshakes.
// Revision: 1.0
// ============================================================================
module sqrt_rr_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [WIDTH/2-1:0]       rsp_q,
  output logic [WIDTH/2:0]         rsp_r,
  output logic                     busy
);

  localparam int c_HW  = WIDTH / 2;
  localparam int c_RW  = c_HW + 2;
  localparam int c_IDW = $clog2(NREQ);
  localparam int c_CW  = $clog2(c_HW);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX, ST_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [c_IDW-1:0]   r_ptr;
  logic [WIDTH-1:0]   r_d;
  logic [c_HW-1:0]    r_q;
  logic [c_RW-1:0]    r_rem;
  logic [c_CW-1:0]    r_cnt;

  logic [c_IDW-1:0]   w_winner, w_idx;
  logic               w_found, w_accept;
  logic [NREQ-1:0]    w_grant;
  logic [WIDTH-1:0]   w_sel_data;
  logic [c_RW-1:0]    w_r_shift, w_r_step;
  logic [c_HW:0]      w_r_fix;

  // Scan from the requester after the last winner, wrapping around.
  always_comb begin
    w_winner   = '0;
    w_idx      = '0;
    w_found    = 1'b0;
    w_grant    = '0;
    w_sel_data = '0;
    for (int off = 1; off <= NREQ; off++) begin
      w_idx = c_IDW'((int'(r_ptr) + off) % NREQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (w_winner == c_IDW'(i)) w_sel_data = req_data[i*WIDTH +: WIDTH];
    end
    if (r_state == ST_IDLE && rst_n && w_found) w_grant[w_winner] = 1'b1;
  end

  assign req_ready = w_grant;
  assign w_accept  = |(w_grant & req_valid);
  assign busy      = (r_state != ST_IDLE);

  // Remainder is two's complement; its sign picks subtract vs add.
  assign w_r_shift = {r_rem[c_RW-3:0], r_d[WIDTH-1 -: 2]};
  assign w_r_step  = r_rem[c_RW-1] ? (w_r_shift + {r_q, 2'b11})
                                   : (w_r_shift - {r_q, 2'b01});
  assign w_r_fix   = r_rem[c_RW-1] ? (r_rem[c_HW:0] + {r_q, 1'b1}) : r_rem[c_HW:0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
      ST_RUN:  if (r_cnt == c_CW'(c_HW - 1)) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_DONE;
      ST_DONE: if (rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= c_IDW'(NREQ - 1);
      r_d       <= '0;
      r_q       <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_q     <= '0;
      rsp_r     <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_d    <= w_sel_data;
            rsp_id <= w_winner;
            r_ptr  <= w_winner;
            r_q    <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
          end
        end
        ST_RUN: begin
          r_rem <= w_r_step;
          r_q   <= {r_q[c_HW-2:0], ~w_r_step[c_RW-1]};
          r_d   <= r_d << 2;
          r_cnt <= r_cnt + 1'b1;
        end
        ST_FIX: begin
          rsp_q     <= r_q;
          rsp_r     <= w_r_fix;
          rsp_valid <= 1'b1;
        end
        ST_DONE: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sqrt_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_sqrt_rr_scheduler
// Purpose : Directed and randomized bench for sqrt_rr_scheduler with a
//           transaction-level reference model compared every cycle.
// Revision: 1.0
// ============================================================================
module tb_sqrt_rr_scheduler;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int HW    = WIDTH / 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*WIDTH-1:0]   req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [1:0]              rsp_id;
  logic [HW-1:0]           rsp_q;
  logic [HW:0]             rsp_r;
  logic                    busy;

  int n_cmp = 0, n_err = 0;
  int accepted = 0, answered = 0, discarded = 0;

  // Reference model state (transaction level)
  bit          m_idle = 1'b1;
  bit          m_rspv = 1'b0;
  int          m_ptr  = NREQ - 1;
  int          m_cnt  = 0;
  int          m_id   = 0;
  logic [63:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0, p_d = '0;

  sqrt_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_r(rsp_r), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] isqrt(input logic [63:0] d);
    logic [63:0] lo, hi, mid;
    lo = 0;
    hi = (64'd1 << HW) - 1;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= d) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  function automatic logic [31:0] rand_d();
    logic [31:0] s;
    s = 32'($urandom_range(0, 65535));
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return s * s;
      3:       return (s == 0) ? 32'h0 : s * s - 1;
      4:       return 32'($urandom_range(0, 1000));
      default: return $urandom;
    endcase
  endfunction

  // Per-cycle compare against the model, then advance the model across the next edge.
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rdy;
    int w, idx;
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_q", rsp_q, 0);
      chk("rst_rsp_r", rsp_r, 0);
      chk("rst_busy", busy, 0);
      if (!m_idle) discarded++;
      m_idle = 1'b1; m_rspv = 1'b0; m_ptr = NREQ - 1; m_id = 0; m_q = 0; m_r = 0;
    end else begin
      exp_rdy = '0;
      w = -1;
      if (m_idle) begin
        for (int k = 1; k <= NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (w < 0 && req_valid[idx]) w = idx;
        end
      end
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      chk("busy", busy, !m_idle);
      chk("rsp_valid", rsp_valid, m_rspv);
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_q", rsp_q, m_q);
      chk("rsp_r", rsp_r, m_r);
      if (w >= 0) begin
        m_idle = 1'b0;
        m_ptr  = w;
        m_id   = w;
        p_d    = {32'h0, req_data[w*WIDTH +: WIDTH]};
        p_q    = isqrt(p_d);
        p_r    = p_d - p_q * p_q;
        m_cnt  = HW + 1;
        accepted++;
      end else if (!m_idle && !m_rspv) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_rspv = 1'b1;
          m_q = p_q;
          m_r = p_r;
        end
      end else if (m_rspv && rsp_ready) begin
        chk("q2_plus_r", 64'(rsp_q) * 64'(rsp_q) + 64'(rsp_r), p_d);
        chk("r_le_2q", 64'(rsp_r) <= 64'(rsp_q) * 2, 1);
        m_rspv = 1'b0;
        m_idle = 1'b1;
        answered++;
      end
    end
  end

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (busy && t < 60) begin @(negedge clk); t++; end
    chk(name, busy, 0);
  endtask

  task automatic run_one(input int id, input logic [31:0] d, input logic [63:0] eq,
                         input logic [63:0] er, input bit chk_lat);
    int t;
    @(posedge clk); #1;
    req_valid[id] = 1'b1;
    req_data[id*WIDTH +: WIDTH] = d;
    rsp_ready = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_ready[id] && t < 40);
    chk("accept_seen", req_ready[id], 1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!rsp_valid && t < 40);
    if (chk_lat) chk("latency", t, 18);
    chk("lit_rsp_valid", rsp_valid, 1);
    chk("lit_rsp_id", rsp_id, id);
    chk("lit_rsp_q", rsp_q, eq);
    chk("lit_rsp_r", rsp_r, er);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  initial begin
    int t, n, g, cyc, target;
    int grants[5];
    int exp_order[5];
    logic [NREQ-1:0] hs;
    exp_order = '{0, 1, 2, 3, 0};
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;

    chk("model_1e6", isqrt(64'd1000000), 64'd1000);
    chk("model_max", isqrt(64'hFFFF_FFFF), 64'hFFFF);
    chk("model_99", isqrt(64'd99), 64'd9);
    chk("model_2", isqrt(64'd2), 64'd1);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed single operations with hand-computed results
    run_one(2, 32'h000F_4240, 64'd1000, 64'd0, 1'b1);
    run_one(0, 32'hFFFF_FFFF, 64'hFFFF, 64'h1FFFE, 1'b0);
    run_one(1, 32'd0, 64'd0, 64'd0, 1'b0);
    run_one(3, 32'd99, 64'd9, 64'd18, 1'b0);
    run_one(0, 32'd2, 64'd1, 64'd1, 1'b0);

    // Response back-pressure: hold DONE for 10 cycles with all requesters waiting
    @(posedge clk); #1;
    req_valid[1] = 1'b1;
    req_data[1*WIDTH +: WIDTH] = 32'd99;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_ready[1] && t < 40);
    @(posedge clk); #1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = rand_d();
    req_data[1*WIDTH +: WIDTH] = 32'd99;
    t = 0;
    do begin @(negedge clk); t++; end while (!rsp_valid && t < 40);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_rsp_q", rsp_q, 9);
      chk("hold_rsp_r", rsp_r, 18);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_busy", busy, 0);
    chk("release_grant", req_ready, 4'b0100);
    @(posedge clk); #1 req_valid = '0;
    wait_idle("drain_hold");
    @(posedge clk); #1 rsp_ready = 1'b0;

    // Grant order from reset with everyone requesting
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    n = 0; t = 0;
    while (n < 5 && t < 200) begin
      @(negedge clk); t++;
      if (|req_ready) begin
        g = -1;
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) g = k;
        grants[n] = g;
        n++;
      end
    end
    chk("grant_count", n, 5);
    for (int i = 0; i < 5; i++) chk("grant_order", grants[i], exp_order[i]);
    @(posedge clk); #1 req_valid = '0;
    wait_idle("drain_rr");
    rsp_ready = 1'b0;

    // Reset in the middle of RUN discards the operation and the pointer
    @(posedge clk); #1;
    req_valid = 4'b0100;
    req_data[2*WIDTH +: WIDTH] = 32'h1234_5678;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_ready[2] && t < 40);
    @(posedge clk); #1 req_valid = '0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    req_valid = '1;
    @(negedge clk);
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_valid", rsp_valid, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle("drain_rst");

    // Randomized traffic; requests are held until accepted
    target = answered + 2000;
    cyc = 0;
    while (answered < target && cyc < 80000) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*WIDTH +: WIDTH] = rand_d();
        end
      end
      rsp_ready = 1'($urandom_range(0, 1));
    end
    chk("random_complete", answered >= target, 1);
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    wait_idle("drain_random");
    @(negedge clk);
    chk("answered_once", answered, accepted - discarded);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
